// File: rtl/stepper_fsm.sv
// Switch-driven WIDTH-bit state stepper (0..LIMIT) advanced on a prescaled tick, with load, range flags and last-op.
// Optional input debounce is built when STEPPER_DEBOUNCE_EN is defined.
module stepper_fsm #(
    parameter int WIDTH      = 4,
    parameter int LIMIT      = 2**WIDTH - 1,
    parameter int STEP       = 2,
    parameter int DIV        = 25000000,
    parameter int DEB_CYCLES = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic [1:0]       sw_i,
    input  logic             wrap_mode_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    output logic [WIDTH-1:0] q_o,
    output logic             tick_o,
    output logic             at_min_o,
    output logic             at_max_o,
    output logic [1:0]       last_op_o
);

    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);
    localparam logic [WIDTH:0]   LIMIT_X  = (WIDTH+1)'(LIMIT);
    localparam logic [WIDTH:0]   STEP_X   = (WIDTH+1)'(STEP);
    localparam logic [WIDTH:0]   MOD_X    = (WIDTH+1)'(LIMIT + 1);
    localparam logic [WIDTH:0]   ONE_X    = (WIDTH+1)'(1);

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} mode_e;

    mode_e            mode_q, mode_d;
    logic             run;
    logic [1:0]       sync1_q, sync2_q;
    logic [1:0]       sw_eff;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic             tick_q, tick_d;
    logic             at_min_q, at_min_d;
    logic             at_max_q, at_max_d;
    logic [1:0]       last_op_q, last_op_d;
    logic [WIDTH:0]   q_x, sum_x, step_x, load_x, next_x;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync1_q <= 2'b10;
            sync2_q <= 2'b10;
        end else begin
            sync1_q <= sw_i;
            sync2_q <= sync1_q;
        end
    end

`ifdef STEPPER_DEBOUNCE_EN
    localparam int DEB_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);

    logic [1:0]       deb_q;
    logic [DEB_W-1:0] deb_cnt_q;

    // Counts clocks the synchronised value has differed from deb_q while holding steady; sync1 != sync2
    // flags that sync2 is about to move, so the count restarts for the new value.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            deb_q     <= 2'b10;
            deb_cnt_q <= '0;
        end else if (sync2_q == deb_q) begin
            deb_cnt_q <= '0;
        end else if (deb_cnt_q == DEB_LAST) begin
            deb_q     <= sync2_q;
            deb_cnt_q <= '0;
        end else if (sync1_q != sync2_q) begin
            deb_cnt_q <= '0;
        end else begin
            deb_cnt_q <= deb_cnt_q + DEB_W'(1);
        end
    end

    assign sw_eff = deb_q;
`else
    assign sw_eff = sync2_q;
`endif

    // Mealy decode so the enable takes effect on the very edge it is first seen.
    always_comb begin
        mode_d = mode_q;
        run    = 1'b0;
        case (mode_q)
            IDLE: begin
                if (en_i) begin
                    mode_d = RUN;
                    run    = 1'b1;
                end
            end
            RUN: begin
                if (en_i) run = 1'b1;
                else      mode_d = IDLE;
            end
            default: mode_d = IDLE;
        endcase
    end

    always_comb begin
        q_x    = {1'b0, q_q};
        load_x = {1'b0, load_val_i};
        sum_x  = q_x + ((sw_eff == 2'b11) ? STEP_X : ONE_X);
        case (sw_eff)
            2'b00, 2'b11: begin
                if (sum_x > LIMIT_X) step_x = wrap_mode_i ? (sum_x - MOD_X) : LIMIT_X;
                else                 step_x = sum_x;
            end
            2'b01: begin
                if (q_x == '0) step_x = wrap_mode_i ? LIMIT_X : '0;
                else           step_x = q_x - ONE_X;
            end
            default: step_x = q_x;
        endcase
    end

    // Load beats the prescaler; a tick only happens on the terminal count of an enabled clock.
    always_comb begin
        next_x    = q_x;
        cnt_d     = cnt_q;
        tick_d    = 1'b0;
        last_op_d = last_op_q;
        if (load_i) begin
            next_x = (load_x > LIMIT_X) ? LIMIT_X : load_x;
            cnt_d  = '0;
        end else if (run) begin
            if (cnt_q == CNT_LAST) begin
                cnt_d     = '0;
                tick_d    = 1'b1;
                next_x    = step_x;
                last_op_d = sw_eff;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
        q_d      = next_x[WIDTH-1:0];
        at_min_d = (next_x == '0);
        at_max_d = (next_x == LIMIT_X);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mode_q    <= IDLE;
            cnt_q     <= '0;
            q_q       <= '0;
            tick_q    <= 1'b0;
            at_min_q  <= 1'b1;
            at_max_q  <= 1'b0;
            last_op_q <= 2'b10;
        end else begin
            mode_q    <= mode_d;
            cnt_q     <= cnt_d;
            q_q       <= q_d;
            tick_q    <= tick_d;
            at_min_q  <= at_min_d;
            at_max_q  <= at_max_d;
            last_op_q <= last_op_d;
        end
    end

    assign q_o       = q_q;
    assign tick_o    = tick_q;
    assign at_min_o  = at_min_q;
    assign at_max_o  = at_max_q;
    assign last_op_o = last_op_q;

endmodule

// File: tb/tb_stepper_fsm.sv
// Directed bench for stepper_fsm at WIDTH=4, LIMIT=9, STEP=2, DIV=4; debounce scenarios need STEPPER_DEBOUNCE_EN.
module tb_stepper_fsm;

    localparam int DEB = 16;
`ifdef STEPPER_DEBOUNCE_EN
    localparam int SETTLE = DEB + 4;
    localparam logic [3:0] RST_EXP_Q = 4'd0;
`else
    localparam int SETTLE = 3;
    localparam logic [3:0] RST_EXP_Q = 4'd1;
`endif

    logic       clk, rst, en, wrapMode, load;
    logic [1:0] sw;
    logic [3:0] loadVal;
    logic [3:0] q;
    logic       tick, atMin, atMax;
    logic [1:0] lastOp;

    int nCompared   = 0;
    int nMismatched = 0;

    stepper_fsm #(.WIDTH(4), .LIMIT(9), .STEP(2), .DIV(4), .DEB_CYCLES(DEB)) dut (
        .clk_i(clk), .rst_i(rst), .en_i(en), .sw_i(sw), .wrap_mode_i(wrapMode),
        .load_i(load), .load_val_i(loadVal), .q_o(q), .tick_o(tick),
        .at_min_o(atMin), .at_max_o(atMax), .last_op_o(lastOp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance n clocks and settle just after the last rising edge.
    task automatic clocks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic doLoad(input logic [3:0] v);
        load = 1'b1; loadVal = v;
        clocks(1);
        load = 1'b0;
    endtask

    task automatic test_reset;
        clocks(2);
        nCompared++; if (q !== 4'd0)       begin nMismatched++; $display("[TB] FAIL reset_q got %0d want 0", q); end
        nCompared++; if (tick !== 1'b0)    begin nMismatched++; $display("[TB] FAIL reset_tick got %b want 0", tick); end
        nCompared++; if (atMin !== 1'b1)   begin nMismatched++; $display("[TB] FAIL reset_at_min got %b want 1", atMin); end
        nCompared++; if (atMax !== 1'b0)   begin nMismatched++; $display("[TB] FAIL reset_at_max got %b want 0", atMax); end
        nCompared++; if (lastOp !== 2'b10) begin nMismatched++; $display("[TB] FAIL reset_last_op got %b want 10", lastOp); end
        rst = 1'b0;
    endtask

    task automatic test_count_wrap;
        sw = 2'b00; wrapMode = 1'b1;
        clocks(SETTLE);
        en = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            logic [3:0] expQ;
            expQ = 4'(k % 10);
            clocks(3);
            nCompared++; if (tick !== 1'b0) begin nMismatched++; $display("[TB] FAIL inc_tick_low k=%0d got %b want 0", k, tick); end
            clocks(1);
            nCompared++; if (tick !== 1'b1) begin nMismatched++; $display("[TB] FAIL inc_tick_high k=%0d got %b want 1", k, tick); end
            nCompared++; if (q !== expQ)    begin nMismatched++; $display("[TB] FAIL inc_q k=%0d got %0d want %0d", k, q, expQ); end
            nCompared++; if (atMax !== (k == 9)) begin nMismatched++; $display("[TB] FAIL inc_at_max k=%0d got %b want %b", k, atMax, (k == 9)); end
        end
        en = 1'b0;
        nCompared++; if (lastOp !== 2'b00) begin nMismatched++; $display("[TB] FAIL inc_last_op got %b want 00", lastOp); end
    endtask

    task automatic test_decrement;
        doLoad(4'd1);
        nCompared++; if (q !== 4'd1) begin nMismatched++; $display("[TB] FAIL dec_load_q got %0d want 1", q); end
        sw = 2'b01; wrapMode = 1'b0;
        clocks(SETTLE);
        en = 1'b1;
        clocks(4);
        nCompared++; if (q !== 4'd0)     begin nMismatched++; $display("[TB] FAIL dec_q got %0d want 0", q); end
        nCompared++; if (tick !== 1'b1)  begin nMismatched++; $display("[TB] FAIL dec_tick got %b want 1", tick); end
        nCompared++; if (atMin !== 1'b1) begin nMismatched++; $display("[TB] FAIL dec_at_min got %b want 1", atMin); end
        clocks(4);
        nCompared++; if (q !== 4'd0) begin nMismatched++; $display("[TB] FAIL dec_sat_q got %0d want 0", q); end
        wrapMode = 1'b1;
        clocks(4);
        nCompared++; if (q !== 4'd9)       begin nMismatched++; $display("[TB] FAIL dec_wrap_q got %0d want 9", q); end
        nCompared++; if (atMax !== 1'b1)   begin nMismatched++; $display("[TB] FAIL dec_wrap_at_max got %b want 1", atMax); end
        nCompared++; if (lastOp !== 2'b01) begin nMismatched++; $display("[TB] FAIL dec_last_op got %b want 01", lastOp); end
        en = 1'b0;
    endtask

    task automatic test_step;
        doLoad(4'd8);
        sw = 2'b11; wrapMode = 1'b1;
        clocks(SETTLE);
        en = 1'b1;
        clocks(4);
        nCompared++; if (q !== 4'd0)       begin nMismatched++; $display("[TB] FAIL step_wrap_q got %0d want 0", q); end
        nCompared++; if (lastOp !== 2'b11) begin nMismatched++; $display("[TB] FAIL step_last_op got %b want 11", lastOp); end
        en = 1'b0; wrapMode = 1'b0;
        doLoad(4'd8);
        en = 1'b1;
        clocks(4);
        nCompared++; if (q !== 4'd9)     begin nMismatched++; $display("[TB] FAIL step_sat_q got %0d want 9", q); end
        nCompared++; if (atMax !== 1'b1) begin nMismatched++; $display("[TB] FAIL step_sat_at_max got %b want 1", atMax); end
        clocks(4);
        nCompared++; if (q !== 4'd9)    begin nMismatched++; $display("[TB] FAIL step_sat_hold_q got %0d want 9", q); end
        nCompared++; if (tick !== 1'b1) begin nMismatched++; $display("[TB] FAIL step_sat_tick got %b want 1", tick); end
        en = 1'b0;
    endtask

    task automatic test_load;
        sw = 2'b00; wrapMode = 1'b1;
        clocks(SETTLE);
        doLoad(4'd0);
        en = 1'b1;
        clocks(3);
        load = 1'b1; loadVal = 4'hF;
        clocks(1);
        load = 1'b0;
        nCompared++; if (q !== 4'd9)     begin nMismatched++; $display("[TB] FAIL load_clamp_q got %0d want 9", q); end
        nCompared++; if (tick !== 1'b0)  begin nMismatched++; $display("[TB] FAIL load_tick got %b want 0", tick); end
        nCompared++; if (atMax !== 1'b1) begin nMismatched++; $display("[TB] FAIL load_at_max got %b want 1", atMax); end
        clocks(3);
        nCompared++; if (tick !== 1'b0) begin nMismatched++; $display("[TB] FAIL load_cnt_tick_low got %b want 0", tick); end
        clocks(1);
        nCompared++; if (tick !== 1'b1) begin nMismatched++; $display("[TB] FAIL load_cnt_tick_high got %b want 1", tick); end
        nCompared++; if (q !== 4'd0)    begin nMismatched++; $display("[TB] FAIL load_next_q got %0d want 0", q); end
        en = 1'b0;
        doLoad(4'd3);
        nCompared++; if (q !== 4'd3)     begin nMismatched++; $display("[TB] FAIL load_idle_q got %0d want 3", q); end
        nCompared++; if (atMin !== 1'b0) begin nMismatched++; $display("[TB] FAIL load_idle_at_min got %b want 0", atMin); end
        clocks(5);
        nCompared++; if (q !== 4'd3)    begin nMismatched++; $display("[TB] FAIL freeze_q got %0d want 3", q); end
        nCompared++; if (tick !== 1'b0) begin nMismatched++; $display("[TB] FAIL freeze_tick got %b want 0", tick); end
    endtask

    task automatic test_reset_mid;
        doLoad(4'd5);
        en = 1'b1;
        clocks(2);
        rst = 1'b1;
        #1;
        nCompared++; if (q !== 4'd0)     begin nMismatched++; $display("[TB] FAIL rst_mid_q got %0d want 0", q); end
        nCompared++; if (tick !== 1'b0)  begin nMismatched++; $display("[TB] FAIL rst_mid_tick got %b want 0", tick); end
        nCompared++; if (atMin !== 1'b1) begin nMismatched++; $display("[TB] FAIL rst_mid_at_min got %b want 1", atMin); end
        clocks(1);
        rst = 1'b0;
        clocks(3);
        nCompared++; if (tick !== 1'b0) begin nMismatched++; $display("[TB] FAIL rst_release_tick_low got %b want 0", tick); end
        clocks(1);
        nCompared++; if (tick !== 1'b1)   begin nMismatched++; $display("[TB] FAIL rst_release_tick_high got %b want 1", tick); end
        nCompared++; if (q !== RST_EXP_Q) begin nMismatched++; $display("[TB] FAIL rst_release_q got %0d want %0d", q, RST_EXP_Q); end
        en = 1'b0;
    endtask

`ifdef STEPPER_DEBOUNCE_EN
    task automatic test_debounce;
        sw = 2'b00; wrapMode = 1'b1;
        clocks(SETTLE);
        doLoad(4'd0);
        sw = 2'b01;
        clocks(5);
        sw = 2'b00;
        clocks(SETTLE);
        en = 1'b1;
        clocks(4);
        en = 1'b0;
        nCompared++; if (q !== 4'd1)       begin nMismatched++; $display("[TB] FAIL deb_glitch_q got %0d want 1", q); end
        nCompared++; if (lastOp !== 2'b00) begin nMismatched++; $display("[TB] FAIL deb_glitch_last_op got %b want 00", lastOp); end
        sw = 2'b01;
        clocks(20);
        en = 1'b1;
        clocks(4);
        en = 1'b0;
        nCompared++; if (q !== 4'd0)       begin nMismatched++; $display("[TB] FAIL deb_change_q got %0d want 0", q); end
        nCompared++; if (lastOp !== 2'b01) begin nMismatched++; $display("[TB] FAIL deb_change_last_op got %b want 01", lastOp); end
    endtask
`endif

    initial begin
        rst = 1'b1; en = 1'b0; sw = 2'b00; wrapMode = 1'b0; load = 1'b0; loadVal = 4'd0;
        test_reset();
        test_count_wrap();
        test_decrement();
        test_step();
        test_load();
        test_reset_mid();
`ifdef STEPPER_DEBOUNCE_EN
        test_debounce();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
